// File: rtl/message_seq_ctrl.sv
// Chip/bit address sequencer for message_gen: PPS-started frames of
// MESSAGE_LEN bits, each bit spanning PCODE_REPEATS p-code periods.
module message_seq_ctrl #(
  parameter int unsigned PCODE_LEN     = 40920,
  parameter int unsigned PCODE_REPEATS = 10,
  parameter int unsigned MESSAGE_LEN   = 120
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           arm,
  input  logic                           abort,
  input  logic                           continuous,
  input  logic                           resync_en,
  input  logic                           pps,
  input  logic                           dac_valid,
  output logic [$clog2(PCODE_LEN)-1:0]   pcode_addr,
  output logic [$clog2(MESSAGE_LEN)-1:0] msg_addr,
  output logic                           running,
  output logic                           frame_start,
  output logic                           frame_done,
  output logic                           tstamp_patch_req,
  output logic                           sync_err
);

  localparam int unsigned CHIP_W = $clog2(PCODE_LEN);
  localparam int unsigned BIT_W  = $clog2(MESSAGE_LEN);
  localparam int unsigned REP_W  = (PCODE_REPEATS > 1) ? $clog2(PCODE_REPEATS) : 1;

  localparam logic [CHIP_W-1:0] CHIP_MAX = CHIP_W'(PCODE_LEN - 1);
  localparam logic [REP_W-1:0]  REP_MAX  = REP_W'(PCODE_REPEATS - 1);
  localparam logic [BIT_W-1:0]  BIT_MAX  = BIT_W'(MESSAGE_LEN - 1);
  localparam logic [CHIP_W-1:0] CHIP_ONE = CHIP_W'(1);
  localparam logic [REP_W-1:0]  REP_ONE  = REP_W'(1);
  localparam logic [BIT_W-1:0]  BIT_ONE  = BIT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_RUN
  } state_t;

  state_t             state, state_n;
  logic [CHIP_W-1:0]  chip_n;
  logic [REP_W-1:0]   rep, rep_n;
  logic [BIT_W-1:0]   bit_n;
  logic               frame_start_n;
  logic               frame_done_n;
  logic               sync_err_n;
  logic               at_zero;
  logic               last_chip;
  logic               last_rep;
  logic               last_bit;
  logic               frame_end;

  assign at_zero   = (pcode_addr == '0) && (rep == '0) && (msg_addr == '0);
  assign last_chip = (pcode_addr == CHIP_MAX);
  assign last_rep  = (rep == REP_MAX);
  assign last_bit  = (msg_addr == BIT_MAX);
  assign frame_end = dac_valid && last_chip && last_rep && last_bit;

  always_comb begin
    state_n       = state;
    chip_n        = pcode_addr;
    rep_n         = rep;
    bit_n         = msg_addr;
    frame_start_n = 1'b0;
    frame_done_n  = 1'b0;
    sync_err_n    = sync_err;

    if (abort) begin
      state_n = S_IDLE;
      chip_n  = '0;
      rep_n   = '0;
      bit_n   = '0;
    end else begin
      case (state)
        S_IDLE: begin
          chip_n = '0;
          rep_n  = '0;
          bit_n  = '0;
          if (arm) begin
            state_n    = S_ARMED;
            sync_err_n = 1'b0;
          end
        end

        S_ARMED: begin
          chip_n = '0;
          rep_n  = '0;
          bit_n  = '0;
          if (pps) begin
            state_n       = S_RUN;
            frame_start_n = 1'b1;
          end
        end

        S_RUN: begin
          // A PPS is aligned when the frame is at its first chip or wraps this beat.
          if (resync_en && pps && !at_zero && !frame_end) begin
            sync_err_n    = 1'b1;
            chip_n        = '0;
            rep_n         = '0;
            bit_n         = '0;
            frame_start_n = 1'b1;
          end else if (dac_valid) begin
            if (frame_end) begin
              frame_done_n = 1'b1;
              chip_n       = '0;
              rep_n        = '0;
              bit_n        = '0;
              if (continuous) begin
                frame_start_n = 1'b1;
              end else begin
                state_n = S_IDLE;
              end
            end else if (last_chip) begin
              chip_n = '0;
              if (last_rep) begin
                rep_n = '0;
                bit_n = msg_addr + BIT_ONE;
              end else begin
                rep_n = rep + REP_ONE;
              end
            end else begin
              chip_n = pcode_addr + CHIP_ONE;
            end
          end
        end

        default: begin
          state_n = S_IDLE;
          chip_n  = '0;
          rep_n   = '0;
          bit_n   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= S_IDLE;
      pcode_addr       <= '0;
      rep              <= '0;
      msg_addr         <= '0;
      running          <= 1'b0;
      frame_start      <= 1'b0;
      frame_done       <= 1'b0;
      tstamp_patch_req <= 1'b0;
      sync_err         <= 1'b0;
    end else begin
      state            <= state_n;
      pcode_addr       <= chip_n;
      rep              <= rep_n;
      msg_addr         <= bit_n;
      running          <= (state_n == S_RUN);
      frame_start      <= frame_start_n;
      frame_done       <= frame_done_n;
      tstamp_patch_req <= frame_start_n;
      sync_err         <= sync_err_n;
    end
  end

endmodule
